// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory-port sequencer for fetch and load/store traffic

package rvcpu;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [31:0] opcode_t;
  typedef logic [2:0]  mem_op_t;

  localparam mem_op_t mem_b  = 3'b000;
  localparam mem_op_t mem_h  = 3'b001;
  localparam mem_op_t mem_w  = 3'b011;
  localparam mem_op_t mem_bu = 3'b100;
  localparam mem_op_t mem_hu = 3'b101;
endpackage

module mem_port_arbiter
  import rvcpu::*;
#(
  parameter int unsigned MaxDataBurst = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_req_i,
  input  addr_t          if_addr_i,
  output logic           if_gnt_o,
  output logic           if_rvalid_o,
  output opcode_t        if_rdata_o,
  output logic           if_err_o,
  input  logic           dm_req_i,
  input  logic           dm_we_i,
  input  mem_op_t        dm_op_i,
  input  addr_t          dm_addr_i,
  input  data_t          dm_wdata_i,
  output logic           dm_gnt_o,
  output logic           dm_rvalid_o,
  output data_t          dm_rdata_o,
  output logic           dm_err_o,
  output logic           bus_req_o,
  output logic           bus_we_o,
  output logic [31:0]    bus_addr_o,
  output logic [3:0]     bus_be_o,
  output logic [31:0]    bus_wdata_o,
  input  logic           bus_gnt_i,
  input  logic           bus_rvalid_i,
  input  logic [31:0]    bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  burst_cnt_q;

  // Transaction owner: 0 = fetch, 1 = data
  logic        owner_q;
  logic        err_q;
  logic        we_q;
  mem_op_t     op_q;
  logic [1:0]  alo_q;

  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;

  logic        burst_full;
  logic        fetch_win;
  logic        data_win;
  logic        if_bad;

  logic [3:0]  dm_be;
  logic [31:0] dm_wdata_rep;
  logic        dm_legal;
  logic        dm_misal;
  logic        dm_bad;

  logic [31:0] lane;
  logic [31:0] load_ext;
  logic        resp_valid;
  logic        resp_err;

  assign burst_full = (burst_cnt_q == 4'(MaxDataBurst));
  assign fetch_win  = (state_q == IDLE) && if_req_i && (!dm_req_i || burst_full);
  assign data_win   = (state_q == IDLE) && dm_req_i && !fetch_win;
  assign if_bad     = |if_addr_i[1:0];
  assign dm_bad     = !dm_legal || dm_misal;

  assign if_gnt_o   = fetch_win;
  assign dm_gnt_o   = data_win;

  // Decode data op into byte enables, replicated store lanes and legality
  always_comb begin
    dm_be        = 4'b0000;
    dm_wdata_rep = dm_wdata_i;
    dm_legal     = 1'b1;
    dm_misal     = 1'b0;
    case (dm_op_i)
      mem_b, mem_bu: begin
        dm_be        = 4'b0001 << dm_addr_i[1:0];
        dm_wdata_rep = {4{dm_wdata_i[7:0]}};
      end
      mem_h, mem_hu: begin
        dm_be        = 4'b0011 << dm_addr_i[1:0];
        dm_wdata_rep = {2{dm_wdata_i[15:0]}};
        dm_misal     = dm_addr_i[0];
      end
      mem_w: begin
        dm_be        = 4'b1111;
        dm_misal     = |dm_addr_i[1:0];
      end
      default: dm_legal = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; faulty requests skip the bus and answer from RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fetch_win)     state_d = if_bad ? RESP : ADDR;
        else if (data_win) state_d = dm_bad ? RESP : ADDR;
      end
      ADDR: if (bus_gnt_i) state_d = RESP;
      RESP: if (err_q || bus_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data burst counter: bounds how long a pending fetch can be passed over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt_q <= 4'd0;
    end else if (fetch_win) begin
      burst_cnt_q <= 4'd0;
    end else if (data_win) begin
      burst_cnt_q <= if_req_i ? burst_cnt_q + 4'd1 : 4'd0;
    end
  end

  // Capture the winner and launch its bus request; drop the request once accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      op_q        <= mem_b;
      alo_q       <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
    end else if (fetch_win) begin
      owner_q   <= 1'b0;
      err_q     <= if_bad;
      we_q      <= 1'b0;
      op_q      <= mem_w;
      alo_q     <= if_addr_i[1:0];
      bus_req_q <= !if_bad;
      if (!if_bad) begin
        bus_we_q   <= 1'b0;
        bus_addr_q <= {if_addr_i[31:2], 2'b00};
        bus_be_q   <= 4'b1111;
      end
    end else if (data_win) begin
      owner_q   <= 1'b1;
      err_q     <= dm_bad;
      we_q      <= dm_we_i;
      op_q      <= dm_op_i;
      alo_q     <= dm_addr_i[1:0];
      bus_req_q <= !dm_bad;
      if (!dm_bad) begin
        bus_we_q    <= dm_we_i;
        bus_addr_q  <= {dm_addr_i[31:2], 2'b00};
        bus_be_q    <= dm_be;
        bus_wdata_q <= dm_wdata_rep;
      end
    end else if (state_q == ADDR && bus_gnt_i) begin
      bus_req_q <= 1'b0;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;

  // Align the addressed lane to bit 0 and extend it by op
  always_comb begin
    lane = bus_rdata_i >> {alo_q, 3'b000};
    case (op_q)
      mem_b:   load_ext = {{24{lane[7]}}, lane[7:0]};
      mem_bu:  load_ext = {24'd0, lane[7:0]};
      mem_h:   load_ext = {{16{lane[15]}}, lane[15:0]};
      mem_hu:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // Route the response to the registered owner only
  always_comb begin
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    if_rvalid_o = 1'b0;
    if_err_o    = 1'b0;
    if_rdata_o  = 32'd0;
    dm_rvalid_o = 1'b0;
    dm_err_o    = 1'b0;
    dm_rdata_o  = 32'd0;
    if (state_q == RESP) begin
      if (err_q) begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
      end else if (bus_rvalid_i) begin
        resp_valid = 1'b1;
      end
    end
    if (resp_valid && !owner_q) begin
      if_rvalid_o = 1'b1;
      if_err_o    = resp_err;
      if_rdata_o  = resp_err ? 32'd0 : bus_rdata_i;
    end
    if (resp_valid && owner_q) begin
      dm_rvalid_o = 1'b1;
      dm_err_o    = resp_err;
      dm_rdata_o  = (resp_err || we_q) ? 32'd0 : load_ext;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares the core's single memory bus port between the instruction-fetch stage and the MEM stage (loads/stores). Arbitrates with data priority plus a starvation bound for fetch, and runs one transaction at a time through a three-state FSM. Generates byte enables and lane-replicated store data from `mem_op_t`, aligns and sign- or zero-extends load data, and flags misaligned accesses without touching the bus. Sits between the IF/MEM stages and the external memory interface; uses the `rvcpu` package types.

## Interface
- `MaxDataBurst`, default 4: max consecutive data grants while fetch is pending; range 1..15.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `if_req_i` in 1: fetch request; held with `if_addr_i` until `if_gnt_o`.
- `if_addr_i` in 32 (`addr_t`): fetch address.
- `if_gnt_o` out 1: fetch request accepted (1-cycle pulse).
- `if_rvalid_o` out 1: fetch response valid (1-cycle pulse).
- `if_rdata_o` out 32 (`opcode_t`): fetched word.
- `if_err_o` out 1: fetch misaligned; qualified by `if_rvalid_o`.
- `dm_req_i` in 1: data request; held with its fields until `dm_gnt_o`.
- `dm_we_i` in 1: 1 = store.
- `dm_op_i` in 3 (`mem_op_t`): access size/sign.
- `dm_addr_i` in 32 (`addr_t`): byte address.
- `dm_wdata_i` in 32 (`data_t`): store data, LSB-justified.
- `dm_gnt_o` out 1: data request accepted (pulse).
- `dm_rvalid_o` out 1: data response valid (pulse, loads and stores).
- `dm_rdata_o` out 32 (`data_t`): extended load data; 0 for stores and errors.
- `dm_err_o` out 1: misaligned or illegal op; qualified by `dm_rvalid_o`.
- `bus_req_o` out 1: bus request.
- `bus_we_o` out 1: bus write enable.
- `bus_addr_o` out 32: word address; bits [1:0] always 0.
- `bus_be_o` out 4: byte enables.
- `bus_wdata_o` out 32: lane-replicated store data.
- `bus_gnt_i` in 1: bus accepted the request.
- `bus_rvalid_i` in 1: bus response; arrives at least 1 cycle after `bus_gnt_i`.
- `bus_rdata_i` in 32: bus read data.

## Operation
- FSM states: IDLE, ADDR, RESP.
  - IDLE -> ADDR: a request is present and legal.
  - IDLE -> RESP: a request is present and misaligned or illegal. Error responses are delivered from RESP without touching the bus.
  - ADDR -> RESP: on `bus_gnt_i`.
  - RESP -> IDLE: on `bus_rvalid_i`, or after one cycle for an error.
- In IDLE, one winner is chosen and its `*_gnt_o` is pulsed in that same cycle (combinational from the requests). All winner fields, the owner, the op and `addr[1:0]` are registered.
- Arbitration:
  - Data wins over fetch, except when `burst_cnt == MaxDataBurst` and `if_req_i` is high; then fetch wins.
  - `burst_cnt` (4 bits) increments on a data grant while `if_req_i`=1.
  - `burst_cnt` clears on a fetch grant, and on a data grant while `if_req_i`=0.
- `bus_*_o` are registered and held stable in ADDR. `bus_req_o` is 0 outside ADDR.
- Fetch transactions: `be`=1111, `we`=0. Misaligned when `addr[1:0]`≠0.
- Data byte enables and store data:
  - `mem_b`/`mem_bu`: `be` = 0001 << `a[1:0]`, `wdata` = 4×`wdata[7:0]`.
  - `mem_h`/`mem_hu`: `be` = 0011 << `a[1:0]`, `wdata` = 2×`wdata[15:0]`. Misaligned if `a[0]`=1.
  - `mem_w`: `be`=1111. Misaligned if `a[1:0]`≠0.
  - Op encodings 010, 110, 111 are illegal and produce an error response.
- Loads: the lane is shifted right by 8×`a[1:0]`, then sign-extended for `mem_b`/`mem_h` and zero-extended for `mem_bu`/`mem_hu`.
- Response outputs are combinational from `bus_rvalid_i`/`bus_rdata_i` in RESP, routed to the registered owner. The other requester's response outputs stay 0.
- `bus_rvalid_i` is ignored outside RESP.

## Timing
- Reset value of every output and of all state: all outputs 0, FSM=IDLE, `burst_cnt`=0.
- Reset mid-transaction abandons it; no response is ever delivered for it.
- Minimum latency, with `bus_gnt_i`=1 in the ADDR cycle and `bus_rvalid_i` one cycle later:
  - `gnt` at cycle 0, `bus_req_o` at cycle 1, `rvalid` at cycle 2.
  - Next grant no earlier than cycle 3.
- Error latency: `gnt` at cycle 0, `rvalid`+`err` at cycle 1.
- Bus stall: the FSM stays in ADDR with fields unchanged for any number of cycles with `bus_gnt_i`=0.
- At most one transaction is outstanding. Requests arriving outside IDLE wait, and no `gnt` is given.
- Both requests arriving in the same IDLE cycle resolve by the arbitration rule; the loser's `gnt_o` stays 0.

## Test plan
- Fetch only, `if_addr_i`=0x100, bus gnt immediate, rdata 0x00000013 -> `if_gnt_o` cycle 0, `bus_addr_o`=0x100 `be`=1111 cycle 1, `if_rdata_o`=0x00000013 cycle 2.
- Load `mem_b` at 0x203, bus rdata 0x80FFFFFF -> `bus_addr_o`=0x200, `be`=1000, `dm_rdata_o`=0xFFFFFF80. Same with `mem_bu` -> 0x00000080.
- Store `mem_h` at 0x302 with `wdata` 0x1234ABCD -> `be`=1100, `bus_wdata_o`=0xABCDABCD, `we`=1, `dm_rvalid_o` with `dm_rdata_o`=0.
- Store `mem_w` at 0x401 -> `dm_gnt_o` then `dm_rvalid_o`=`dm_err_o`=1 next cycle, `bus_req_o` never asserted.
- `if_req_i` and `dm_req_i` held high continuously, `MaxDataBurst`=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- `bus_gnt_i` low 5 cycles, then `rst` pulsed in RESP -> bus fields stable throughout ADDR; after reset all outputs 0 and no `rvalid` for the abandoned access.
